// File: rtl/uart_pkg.sv
// Shared UART line definitions: transmitter state encoding, frame bit levels and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic StartBitLevel = 1'b0;
    localparam logic StopBitLevel  = 1'b1;
    localparam logic IdleLevel     = 1'b1;

    // Caller zero-extends narrower bytes, so unused upper bits never disturb the result.
    function automatic logic frame_parity(input logic [8:0] bits, input logic odd);
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART serialiser: start bit, LSB-first data, optional parity, stop bit(s); one bit per bit_trigger.
// Latency: tx falls the cycle after the first bit_trigger that follows the byte transfer.
// Backpressure: data_ready only in IDLE or during the final stop bit, and only while no byte is held.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DataBits     = 8,
    parameter int StopBits     = 1,
    parameter int ParityEnable = 0,
    parameter int ParityOdd    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_trigger,
    input  logic [DataBits-1:0] data,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                tx,
    output logic                busy
);

    localparam int              IdxW     = (DataBits > 1) ? $clog2(DataBits) : 1;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DataBits - 1);
    localparam logic            LastStop = 1'(StopBits - 1);

    tx_state_e           state_q, state_d;
    logic [DataBits-1:0] shreg_q, shreg_d;
    logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                par_q, par_d;
    logic                pending_q, pending_d;
    logic                tx_q, tx_d;
    logic                ready_en_q;
    logic                xfer;
    logic                last_stop;
    logic [8:0]          data_wide;

    always_comb begin
        data_wide                 = '0;
        data_wide[DataBits-1:0]   = data;
    end

    assign last_stop  = (state_q == STOP) && (stop_cnt_q == LastStop);
    // ready_en_q keeps data_ready low for the first cycle after reset is released.
    assign data_ready = !rst && ready_en_q && !pending_q && ((state_q == IDLE) || last_stop);
    assign xfer       = data_valid && data_ready;
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            pending_q  <= 1'b0;
            tx_q       <= IdleLevel;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            pending_q  <= pending_d;
            tx_q       <= tx_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        pending_d  = pending_q;
        tx_d       = tx_q;

        // A byte accepted on a trigger edge sees pending_q=0, so it waits for the next trigger.
        if (xfer) begin
            shreg_d   = data;
            par_d     = frame_parity(data_wide, 1'(ParityOdd));
            pending_d = 1'b1;
        end

        if (bit_trigger) begin
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_d   = START;
                        tx_d      = StartBitLevel;
                        pending_d = 1'b0;
                    end
                end
                START: begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
                DATA: begin
                    if (bit_idx_q == LastIdx) begin
                        if (ParityEnable != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d    = STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = StopBitLevel;
                        end
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + IdxW'(1);
                        tx_d      = shreg_q[1];
                    end
                end
                PARITY: begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = StopBitLevel;
                end
                STOP: begin
                    if (stop_cnt_q != LastStop) begin
                        stop_cnt_d = 1'b1;
                    end else if (pending_q) begin
                        state_d   = START;
                        tx_d      = StartBitLevel;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = IdleLevel;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = IdleLevel;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four configurations share clock, reset and a 10-cycle bit trigger.
module tb_uart_transmitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic bit_trigger = 1'b0;
    int   tcnt = 0;

    // Baud pulse source: one single-cycle pulse every 10 clocks.
    always @(posedge clk) begin
        tcnt        <= (tcnt == 9) ? 0 : tcnt + 1;
        bit_trigger <= (tcnt == 8);
    end

    logic [3:0] tx_w, ready_w, busy_w;
    logic [3:0] valid_w = '0;
    logic [8:0] data_w [4];

    uart_transmitter #(.DataBits(8), .StopBits(1), .ParityEnable(0), .ParityOdd(0)) u_def (
        .clk(clk), .rst(rst), .bit_trigger(bit_trigger), .data(data_w[0][7:0]),
        .data_valid(valid_w[0]), .data_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_transmitter #(.DataBits(8), .StopBits(1), .ParityEnable(1), .ParityOdd(0)) u_even (
        .clk(clk), .rst(rst), .bit_trigger(bit_trigger), .data(data_w[1][7:0]),
        .data_valid(valid_w[1]), .data_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_transmitter #(.DataBits(8), .StopBits(1), .ParityEnable(1), .ParityOdd(1)) u_odd (
        .clk(clk), .rst(rst), .bit_trigger(bit_trigger), .data(data_w[2][7:0]),
        .data_valid(valid_w[2]), .data_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_transmitter #(.DataBits(7), .StopBits(2), .ParityEnable(0), .ParityOdd(0)) u_d7s2 (
        .clk(clk), .rst(rst), .bit_trigger(bit_trigger), .data(data_w[3][6:0]),
        .data_valid(valid_w[3]), .data_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    int cfg_nb [4] = '{8, 8, 8, 7};
    int cfg_pe [4] = '{0, 1, 1, 0};
    int cfg_po [4] = '{0, 0, 1, 0};
    int cfg_ns [4] = '{1, 1, 1, 2};

    int n_chk  = 0;
    int n_fail = 0;

    logic       exp_q[$];
    logic       trc_tx[$];
    logic       trc_busy[$];
    logic [8:0] send_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: the line levels of every bit, in transmission order.
    function automatic void add_frame(input int inst, input logic [8:0] b);
        int ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < cfg_nb[inst]; i++) begin
            exp_q.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (cfg_pe[inst] != 0) exp_q.push_back(((ones + cfg_po[inst]) % 2) == 1);
        for (int i = 0; i < cfg_ns[inst]; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic run(input int inst, input string name);
        int ncyc;
        int first;
        int nsamp;
        exp_q.delete();
        foreach (send_q[k]) add_frame(inst, send_q[k]);
        nsamp = exp_q.size() * 10;
        ncyc  = nsamp + 40;
        trc_tx.delete();
        trc_busy.delete();
        fork
            begin
                foreach (send_q[k]) begin
                    int waited = 0;
                    @(negedge clk);
                    valid_w[inst] = 1'b1;
                    data_w[inst]  = send_q[k];
                    while (!ready_w[inst] && waited < 400) begin
                        @(negedge clk);
                        waited++;
                    end
                    chk($sformatf("%s_accept%0d", name, k), 32'(ready_w[inst]), 1);
                    @(posedge clk);
                end
                @(negedge clk);
                valid_w[inst] = 1'b0;
            end
            begin
                repeat (ncyc) begin
                    @(negedge clk);
                    trc_tx.push_back(tx_w[inst]);
                    trc_busy.push_back(busy_w[inst]);
                end
            end
        join
        first = -1;
        foreach (trc_tx[i]) begin
            if (first < 0 && trc_tx[i] === 1'b0) first = i;
        end
        chk({name, "_start_seen"}, 32'(first >= 0), 1);
        if (first < 0 || first + nsamp >= trc_tx.size()) return;
        if (first > 0) begin
            chk({name, "_pre_idle_tx"}, 32'(trc_tx[first-1]), 1);
            chk({name, "_pre_idle_busy"}, 32'(trc_busy[first-1]), 0);
        end
        for (int j = 0; j < nsamp; j++) begin
            chk($sformatf("%s_bit%0d_c%0d", name, j / 10, j % 10), 32'(trc_tx[first+j]), 32'(exp_q[j / 10]));
            chk($sformatf("%s_busy_c%0d", name, j), 32'(trc_busy[first+j]), 1);
        end
        chk({name, "_end_tx"}, 32'(trc_tx[first+nsamp]), 1);
        chk({name, "_end_busy"}, 32'(trc_busy[first+nsamp]), 0);
        @(negedge clk);
        chk({name, "_end_ready"}, 32'(ready_w[inst]), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        for (int i = 0; i < 4; i++) data_w[i] = 9'h1FF;

        // Reset held with upstream offering data on every instance.
        valid_w = 4'hF;
        rst     = 1'b1;
        @(posedge clk);
        repeat (200) begin
            @(negedge clk);
            chk("reset_hold", 32'({tx_w, busy_w, ready_w}), 32'h0F00);
        end
        valid_w = 4'h0;
        rst     = 1'b0;
        #1;
        chk("reset_release_ready", 32'(ready_w), 0);
        @(negedge clk);
        chk("post_reset_ready", 32'(ready_w), 32'hF);
        chk("post_reset_tx", 32'(tx_w), 32'hF);

        send_q = '{9'h0A5};             run(0, "single_a5");
        send_q = '{9'h000, 9'h0FF};     run(0, "b2b_00_ff");
        send_q = '{9'h0A5};             run(1, "par_even_a5");
        send_q = '{9'h0A5};             run(2, "par_odd_a5");
        send_q = '{9'h001};             run(1, "par_even_01");
        send_q = '{9'h055};             run(3, "d7s2_55");

        for (int r = 0; r < 12; r++) begin
            int inst = int'($urandom_range(0, 3));
            int n    = int'($urandom_range(1, 3));
            send_q.delete();
            for (int k = 0; k < n; k++) send_q.push_back(9'($urandom()));
            run(inst, $sformatf("rand%0d_i%0d", r, inst));
        end

        // Reset during data bit 3 of an all-zero byte.
        @(negedge clk);
        valid_w[0] = 1'b1;
        data_w[0]  = 9'h000;
        @(posedge clk);
        @(negedge clk);
        valid_w[0] = 1'b0;
        first = 0;
        while (tx_w[0] !== 1'b0 && first < 40) begin
            @(negedge clk);
            first++;
        end
        chk("midrst_start_seen", 32'(tx_w[0]), 0);
        repeat (44) @(negedge clk);
        chk("midrst_in_bit3", 32'({tx_w[0], busy_w[0]}), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_first_edge_tx", 32'(tx_w[0]), 1);
        repeat (20) begin
            @(negedge clk);
            chk("midrst_hold", 32'({tx_w[0], busy_w[0], ready_w[0]}), 32'h4);
        end
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 32'(ready_w[0]), 0);
        send_q = '{9'h03C};             run(0, "after_rst_3c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
